nonce_collector: RTL and testbench
==================================

Name: nonce_collector

Overview:
- Collects winning nonces from NCORE K12 PoW cores and serialises them to the host interface.
- Replaces the wired-OR nonce bus so simultaneous finds are never corrupted.
- Each core gets a 1-deep holding register; a round-robin arbiter moves held results into a shared FIFO, which drains through a valid/ready port.
- Sits between the PoW core array and the host/UART result path.

Parameters:
- NCORE, 2, number of PoW cores (≥1).
- DEPTH, 8, output FIFO entries (power of two, ≥2).
- NW, 64, nonce width in bits.
- CW, max(1,clog2(NCORE)), core-index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pending results on job load/halt.
- core_valid  in  NCORE  1-cycle strobe per core: nonce found.
- core_nonce  in  NCORE*NW  nonce of core i at [i*NW +: NW], sampled when core_valid[i]=1.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid&out_ready.
- out_nonce  out  NW  head nonce.
- out_core  out  CW  index of the core that produced the head.
- fifo_count  out  clog2(DEPTH)+1  entries in FIFO.
- overflow  out  NCORE  sticky per-core drop flag.
- drop_count  out  16  saturating count of dropped nonces.
- clear_stats  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (async, rst=1): holding regs empty, FIFO empty, rr pointer=0, overflow=0, drop_count=0. Outputs: out_valid=0, fifo_count=0, out_nonce=0, out_core=0.
- Holding reg i: if core_valid[i] and (reg empty or reg granted this cycle), load core_nonce slice and set pending[i] next edge.
  - If core_valid[i] while pending[i] and not granted: discard new nonce, keep old, set overflow[i], increment drop_count saturating at 16'hFFFF.
- Arbiter, evaluated every cycle when flush=0 and fifo_count<DEPTH using registered count (a pop in the same cycle does not free space for that cycle's grant):
  - grant = first pending index scanning ptr, ptr+1, … wrapping mod NCORE;
  - push {index, nonce} into FIFO; clear pending[grant] unless reloaded the same cycle; ptr <= grant+1 mod NCORE.
  - No pending or FIFO full: no grant, ptr unchanged.
- Latency: core_valid at edge t → pending at t+1 → pushed at t+2 → out_valid=1 after edge t+2 if FIFO was empty and no other grant won. Minimum 2 cycles.
- FIFO: out_valid = (fifo_count≠0); out_nonce/out_core show head entry directly (first-word-fall-through). Pop on out_valid&out_ready. Push and pop in the same cycle leave count unchanged. out_ready while empty is ignored. Pointers wrap mod DEPTH.
- Full: pending results wait in holding regs; further strobes for pending cores are dropped per the drop rule.
- flush=1: next edge clears all pending, the FIFO (count=0), and ptr=0. No grant or pop occurs that cycle. core_valid coincident with flush is discarded and not counted as a drop. overflow and drop_count are retained.
- clear_stats: next edge zeroes overflow and drop_count. If a drop occurs in the same cycle, the clear wins.
- rst asserted mid-operation: immediate clear of all state; in-flight nonces are lost.

Test Plan:
- NCORE=2, core 0 valid with nonce 0x1111 at cycle 5 → out_valid rises after edge 7, out_nonce=0x1111, out_core=0; out_ready=1 → count returns to 0 next edge.
- Both cores valid in the same cycle (0xAAAA, 0xBBBB), ptr=0 → FIFO order core0 then core1; ptr=0 again after both grants; the next simultaneous pair is also ordered 0,1.
- Core 1 strobes 0xC1 then 0xC2 on consecutive cycles while FIFO is full (out_ready=0, DEPTH pre-filled) → 0xC1 held, 0xC2 dropped, overflow=2'b10, drop_count=1; drain → 0xC1 emerges.
- FIFO at count=DEPTH with out_ready=1 and a pending entry → pop occurs, no push that cycle, push on the following cycle; count goes DEPTH→DEPTH-1→DEPTH.
- flush with 3 entries queued, 1 pending, and a coincident core_valid → count=0, out_valid=0, drop_count unchanged, next out_valid only for post-flush strobes.
- rst pulsed asynchronously mid-drain → out_valid falls without a clock edge; drop_count saturation is checked separately by forcing 65540 drops → 16'hFFFF.

Source files
------------

// File: rtl/nonce_collector.sv
// nonce_collector: gathers winning nonces from NCORE PoW cores into one stream.
// Each core owns a 1-deep holding register. A round-robin arbiter moves one held
// result per cycle into a first-word-fall-through FIFO, which drains over valid/ready.
module nonce_collector #(
  parameter  int NCORE = 2,
  parameter  int DEPTH = 8,
  parameter  int NW    = 64,
  localparam int CW    = (NCORE > 1) ? $clog2(NCORE) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NCORE-1:0]    core_valid,
  input  logic [NCORE*NW-1:0] core_nonce,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NW-1:0]       out_nonce,
  output logic [CW-1:0]       out_core,
  output logic [AW:0]         fifo_count,
  output logic [NCORE-1:0]    overflow,
  output logic [15:0]         drop_count,
  input  logic                clear_stats
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [NCORE-1:0]          r_pend;
  logic [NCORE-1:0][NW-1:0]  r_hold;
  logic [CW-1:0]             r_ptr;
  logic [DEPTH-1:0][NW-1:0]  r_mem_n;
  logic [DEPTH-1:0][CW-1:0]  r_mem_c;
  logic [AW-1:0]             r_wp, r_rp;
  logic [AW:0]               r_cnt;
  logic [NCORE-1:0]          r_ovf;
  logic [15:0]               r_drop;

  logic                      w_gv;
  logic [CW-1:0]             w_gidx;
  logic [CW-1:0]             w_ptr_nxt;
  logic [NW-1:0]             w_gnonce;
  logic [NCORE-1:0]          w_gnt, w_load, w_drop;
  logic                      w_pop;
  logic [16:0]               w_dsum;
  int                        w_idx;

  // Round-robin pick: first pending core scanning from r_ptr, only when the
  // registered count shows room (a same-cycle pop does not open a slot).
  always_comb begin
    w_gv     = 1'b0;
    w_gidx   = '0;
    w_gnonce = '0;
    w_idx    = 0;
    if (!flush && (r_cnt < LP_FULL)) begin
      for (int k = 0; k < NCORE; k++) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= NCORE) w_idx = w_idx - NCORE;
        for (int j = 0; j < NCORE; j++) begin
          if (!w_gv && (j == w_idx) && r_pend[j]) begin
            w_gv     = 1'b1;
            w_gidx   = CW'(j);
            w_gnonce = r_hold[j];
          end
        end
      end
    end
  end

  // Pointer advances to the core after the winner, wrapping mod NCORE.
  always_comb begin
    w_ptr_nxt = w_gidx + CW'(1);
    if (int'(w_gidx) == NCORE - 1) w_ptr_nxt = '0;
  end

  // Per-core load/drop decisions; a core granted this cycle can accept a new nonce.
  always_comb begin
    w_gnt  = '0;
    w_load = '0;
    w_drop = '0;
    for (int i = 0; i < NCORE; i++) begin
      w_gnt[i]  = w_gv && (int'(w_gidx) == i);
      w_load[i] = core_valid[i] && !flush && (!r_pend[i] || w_gnt[i]);
      w_drop[i] = core_valid[i] && !flush && r_pend[i] && !w_gnt[i];
    end
  end

  // Saturating drop counter next value; several cores may drop in one cycle.
  always_comb begin
    w_dsum = {1'b0, r_drop};
    for (int i = 0; i < NCORE; i++) begin
      if (w_drop[i]) w_dsum = w_dsum + 17'd1;
    end
    if (w_dsum[16]) w_dsum = 17'h0FFFF;
  end

  assign w_pop = out_valid && out_ready && !flush;

  // Holding registers: reload wins over the clear from a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_hold <= '0;
    end else if (flush) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) begin
        if (w_load[i]) begin
          r_pend[i] <= 1'b1;
          r_hold[i] <= core_nonce[i*NW +: NW];
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_ptr <= '0;
    else if (flush) r_ptr <= '0;
    else if (w_gv)  r_ptr <= w_ptr_nxt;
  end

  // Output FIFO: push from the arbiter, pop on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_n <= '0;
      r_mem_c <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_gv) begin
        r_mem_n[r_wp] <= w_gnonce;
        r_mem_c[r_wp] <= w_gidx;
        r_wp          <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_gv && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_gv && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // Sticky drop statistics; clear_stats beats a same-cycle drop, flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= '0;
      r_drop <= '0;
    end else if (clear_stats) begin
      r_ovf  <= '0;
      r_drop <= '0;
    end else begin
      r_ovf  <= r_ovf | w_drop;
      r_drop <= w_dsum[15:0];
    end
  end

  assign out_valid  = (r_cnt != '0);
  assign out_nonce  = r_mem_n[r_rp];
  assign out_core   = r_mem_c[r_rp];
  assign fifo_count = r_cnt;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: table-driven vectors plus hand sequences for full/flush/reset/saturation.
module tb_nonce_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [1:0]   core_valid;
  logic [127:0] core_nonce;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_nonce;
  logic [0:0]   out_core;
  logic [3:0]   fifo_count;
  logic [1:0]   overflow;
  logic [15:0]  drop_count;
  logic         clear_stats;

  int n_chk = 0;
  int n_err = 0;

  nonce_collector #(.NCORE(2), .DEPTH(8), .NW(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .core_valid(core_valid),
    .core_nonce(core_nonce), .out_valid(out_valid), .out_ready(out_ready),
    .out_nonce(out_nonce), .out_core(out_core), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [1:0]  cv;
    logic [63:0] n0, n1;
    logic        rdy;
    logic        clr;
    logic        ov;
    logic [63:0] on;
    logic        oc;
    logic [3:0]  cnt;
    logic [1:0]  ovf;
    logic [15:0] drop;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic fl, logic [1:0] cv, logic [63:0] n0, logic [63:0] n1,
                              logic rdy, logic ov, logic [63:0] on, logic oc, logic [3:0] cnt);
    vec_t v;
    v.fl = fl; v.cv = cv; v.n0 = n0; v.n1 = n1; v.rdy = rdy; v.clr = 1'b0;
    v.ov = ov; v.on = on; v.oc = oc; v.cnt = cnt; v.ovf = 2'b00; v.drop = 16'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic fl, input logic [1:0] cv, input logic [63:0] a,
                      input logic [63:0] b, input logic rdy, input logic clr);
    flush = fl; core_valid = cv; core_nonce = {b, a}; out_ready = rdy; clear_stats = clr;
    @(posedge clk);
    #1;
    flush = 1'b0; core_valid = 2'b00; out_ready = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, 64'd0, 64'd0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; core_valid = 2'b00; core_nonce = '0;
    out_ready = 1'b0; clear_stats = 1'b0;

    //          fl  cv     n0        n1        rdy  ov  on       oc  cnt
    vt[0]  = mk(0, 2'b01, 64'h1111, 64'h0,    0,   0, 64'h0,    0,  4'd0);
    vt[1]  = mk(0, 2'b00, 64'h0,    64'h0,    0,   1, 64'h1111, 0,  4'd1);
    vt[2]  = mk(0, 2'b00, 64'h0,    64'h0,    1,   0, 64'h0,    0,  4'd0);
    vt[3]  = mk(1, 2'b00, 64'h0,    64'h0,    0,   0, 64'h0,    0,  4'd0);
    vt[4]  = mk(0, 2'b11, 64'hAAAA, 64'hBBBB, 0,   0, 64'h0,    0,  4'd0);
    vt[5]  = mk(0, 2'b00, 64'h0,    64'h0,    0,   1, 64'hAAAA, 0,  4'd1);
    vt[6]  = mk(0, 2'b00, 64'h0,    64'h0,    0,   1, 64'hAAAA, 0,  4'd2);
    vt[7]  = mk(0, 2'b11, 64'hCCCC, 64'hDDDD, 1,   1, 64'hBBBB, 1,  4'd1);
    vt[8]  = mk(0, 2'b00, 64'h0,    64'h0,    1,   1, 64'hCCCC, 0,  4'd1);
    vt[9]  = mk(0, 2'b00, 64'h0,    64'h0,    1,   1, 64'hDDDD, 1,  4'd1);
    vt[10] = mk(0, 2'b00, 64'h0,    64'h0,    1,   0, 64'h0,    0,  4'd0);
    vt[11] = mk(0, 2'b01, 64'h11,   64'h0,    0,   0, 64'h0,    0,  4'd0);
    vt[12] = mk(0, 2'b01, 64'h12,   64'h0,    0,   1, 64'h11,   0,  4'd1);
    vt[13] = mk(0, 2'b00, 64'h0,    64'h0,    0,   1, 64'h11,   0,  4'd2);
    vt[14] = mk(0, 2'b00, 64'h0,    64'h0,    1,   1, 64'h12,   0,  4'd1);
    vt[15] = mk(0, 2'b00, 64'h0,    64'h0,    1,   0, 64'h0,    0,  4'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_nonce", out_nonce, 64'd0);
    chk("rst_core", 64'(out_core), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;

    // Latency, round-robin ordering, reload-while-granted
    for (int i = 0; i < 16; i++) begin
      step(vt[i].fl, vt[i].cv, vt[i].n0, vt[i].n1, vt[i].rdy, vt[i].clr);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vt[i].cnt));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vt[i].ovf));
      chk($sformatf("v%0d_drop", i), 64'(drop_count), 64'(vt[i].drop));
      if (vt[i].ov) begin
        chk($sformatf("v%0d_nonce", i), out_nonce, vt[i].on);
        chk($sformatf("v%0d_core", i), 64'(out_core), 64'(vt[i].oc));
      end
    end

    // Full FIFO: hold one, drop the next; pop frees a slot only for the following cycle
    for (int k = 0; k < 8; k++) step(1'b0, 2'b01, 64'h100 + 64'(k), 64'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("full_count", 64'(fifo_count), 64'd8);
    step(1'b0, 2'b10, 64'd0, 64'hC1, 1'b0, 1'b0);
    chk("hold_count", 64'(fifo_count), 64'd8);
    chk("hold_drop", 64'(drop_count), 64'd0);
    step(1'b0, 2'b10, 64'd0, 64'hC2, 1'b0, 1'b0);
    chk("drop_ovf", 64'(overflow), 64'h2);
    chk("drop_cnt", 64'(drop_count), 64'd1);
    idle(1'b1);
    chk("pop_nopush", 64'(fifo_count), 64'd7);
    idle(1'b0);
    chk("push_after", 64'(fifo_count), 64'd8);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("drain%0d_nonce", k), out_nonce, 64'h100 + 64'(k));
      chk($sformatf("drain%0d_core", k), 64'(out_core), 64'd0);
      idle(1'b1);
    end
    chk("held_nonce", out_nonce, 64'hC1);
    chk("held_core", 64'(out_core), 64'd1);
    idle(1'b1);
    chk("drained", 64'(fifo_count), 64'd0);

    // Flush with queued entries, a pending core and coincident strobes
    step(1'b0, 2'b01, 64'h201, 64'd0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 64'h202, 64'd0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 64'h203, 64'd0, 1'b0, 1'b0);
    step(1'b0, 2'b10, 64'd0, 64'h2B1, 1'b0, 1'b0);
    chk("preflush_cnt", 64'(fifo_count), 64'd3);
    step(1'b1, 2'b11, 64'h2F0, 64'h2F1, 1'b1, 1'b0);
    chk("flush_cnt", 64'(fifo_count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_drop", 64'(drop_count), 64'd1);
    chk("flush_ovf", 64'(overflow), 64'h2);
    idle(1'b0);
    idle(1'b0);
    chk("postflush_valid", 64'(out_valid), 64'd0);
    chk("postflush_cnt", 64'(fifo_count), 64'd0);
    step(1'b0, 2'b10, 64'd0, 64'h2C1, 1'b0, 1'b0);
    idle(1'b0);
    chk("newres_valid", 64'(out_valid), 64'd1);
    chk("newres_nonce", out_nonce, 64'h2C1);
    chk("newres_core", 64'(out_core), 64'd1);
    idle(1'b1);
    step(1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);

    // Asynchronous reset mid-drain
    step(1'b0, 2'b01, 64'h301, 64'd0, 1'b0, 1'b0);
    step(1'b0, 2'b01, 64'h302, 64'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("middrain_cnt", 64'(fifo_count), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_cnt", 64'(fifo_count), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_rst_valid", 64'(out_valid), 64'd0);

    // Drop counter saturation: two cores dropping every cycle behind a full FIFO
    for (int k = 0; k < 8; k++) step(1'b0, 2'b01, 64'h400 + 64'(k), 64'd0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 2'b11, 64'h4A, 64'h4B, 1'b0, 1'b0);
    chk("sat_pre", 64'(drop_count), 64'd0);
    for (int k = 0; k < 100; k++) step(1'b0, 2'b11, 64'h5A, 64'h5B, 1'b0, 1'b0);
    chk("sat_mid", 64'(drop_count), 64'd200);
    for (int k = 0; k < 32670; k++) step(1'b0, 2'b11, 64'h5A, 64'h5B, 1'b0, 1'b0);
    chk("sat_drop", 64'(drop_count), 64'hFFFF);
    chk("sat_ovf", 64'(overflow), 64'h3);
    chk("sat_cnt", 64'(fifo_count), 64'd8);
    step(1'b0, 2'b11, 64'h5A, 64'h5B, 1'b0, 1'b1);
    chk("clrwin_drop", 64'(drop_count), 64'd0);
    chk("clrwin_ovf", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
